mc_maindec: RTL
===============

MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 SHALL have no parameters; all encodings come from the shared package.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 op  in  6  instruction opcode from the instruction register.
REQ-005 mem_ready  in  1  memory handshake; high when the current access completes this cycle.
REQ-006 aluop  out  2  ALU operation class, consumed by the downstream ALU decoder with funct (00 add, 01 sub, 10 funct-defined).
REQ-007 alusrca  out  1  ALU A select (0 PC, 1 register A).
REQ-008 alusrcb  out  2  ALU B select (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2).
REQ-009 pcsrc  out  2  PC source (00 ALU result, 01 ALUOut, 10 jump target).
REQ-010 iord, irwrite, memwrite, regwrite, regdst, memtoreg, pcwrite, branch  out  1 each  standard multicycle datapath controls.
REQ-011 illegal_op  out  1  sticky flag for an unrecognised opcode.
REQ-012 state  out  4  current FSM state, for debug.

Function
REQ-013 SHALL be a Moore FSM; all outputs derive from registered state only, except the mem_ready gating in REQ-017/019/021.
REQ-014 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQ, ADDIEX, ADDIWB, JUMP, HALT.
REQ-015 Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
REQ-016 Every output not listed for a state SHALL be 0.
REQ-017 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready; holds until mem_ready=1, then goes to DECODE.
REQ-018 DECODE: alusrca=0, alusrcb=11, aluop=00; next state by op:
- lw/sw -> MEMADR
- R-type -> EXECUTE
- beq -> BEQ
- addi -> ADDIEX
- j -> JUMP
- any other op -> HALT
REQ-019 MEMADR: alusrca=1, alusrcb=10, aluop=00; next state MEMRD for lw, MEMWR for sw. MEMRD: iord=1; holds until mem_ready, then goes to MEMWB.
REQ-020 MEMWB: regwrite=1, memtoreg=1, regdst=0; next state FETCH.
REQ-021 MEMWR: iord=1, memwrite=1 held every cycle until mem_ready=1; then goes to FETCH.
REQ-022 EXECUTE: alusrca=1, alusrcb=00, aluop=10; next state ALUWB. ALUWB: regwrite=1, regdst=1, memtoreg=0; next state FETCH.
REQ-023 BEQ: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; next state FETCH.
REQ-024 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next state ADDIWB. ADDIWB: regwrite=1, regdst=0, memtoreg=0; next state FETCH.
REQ-025 JUMP: pcsrc=10, pcwrite=1; next state FETCH.
REQ-026 HALT: illegal_op=1 and all write enables 0; HALT is absorbing until reset.
REQ-027 Instruction latencies with mem_ready always 1: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles. Each wait cycle adds one cycle.
REQ-028 An unreachable state encoding SHALL transition to FETCH on the next edge.

Reset
REQ-029 While reset=0, state SHALL be FETCH immediately (asynchronous) and illegal_op=0.
REQ-030 While reset=0, irwrite, pcwrite, memwrite and regwrite SHALL be forced to 0, regardless of mem_ready.
REQ-031 Reset asserted mid-instruction (including while MEMWR is stalled) SHALL abort the instruction; no write enable may be high on the following edge.
REQ-032 The first post-reset cycle SHALL be FETCH.

Structure
REQ-033 Package mc_pkg SHALL hold the state encoding, opcode constants and aluop codes; the downstream ALU decoder shares the same aluop codes.
REQ-034 SHALL be implemented as one sub-module, mc_outdec (combinational state -> control word), plus the state register and next-state logic in mc_maindec.

Verification
REQ-035 lw (op 100011), mem_ready=1 -> state sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1, memtoreg=1 only in cycle 5.
REQ-036 sw, mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH; regwrite never 1.
REQ-037 R-type -> aluop=10 in EXECUTE; beq -> aluop=01, branch=1, pcsrc=01 in BEQ.
REQ-038 op 111111 -> HALT; illegal_op=1 held for 10 cycles; reset pulse clears it and returns to FETCH.
REQ-039 FETCH with mem_ready=0 for 2 cycles -> irwrite=pcwrite=0 for 2 cycles, then 1 for one cycle, then DECODE.
REQ-040 reset asserted in MEMWR mid-stall -> memwrite=0 immediately (asynchronous); state=FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main decoder: FSM states, opcodes,
// ALU operation classes and the packed control word.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQ     = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Shared with the downstream ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       pcwrite;
    logic       branch;
    logic       illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control word decode. Only FETCH looks at
// mem_ready, so the instruction register and PC load on the completing cycle.
module mc_outdec
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: default the whole word first so no branch can leave a field unassigned and infer a latch.
    ctrl = CTRL_IDLE;
    case (state)
      FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PC_ALU;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH2;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      BEQ: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      ADDIWB: ctrl.regwrite = 1'b1;
      JUMP: begin
        ctrl.pcsrc   = PC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      HALT:    ctrl.illegal_op = 1'b1;
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main decoder: Moore FSM sequencing the datapath per opcode.
// Write enables are additionally masked by reset so nothing commits while held.
module mc_maindec
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic [1:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcwrite,
  output logic       branch,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = HALT;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      HALT:    state_d = HALT;
      MEMWB, ALUWB, BEQ, ADDIWB, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  always_comb begin
    aluop      = ctrl.aluop;
    alusrca    = ctrl.alusrca;
    alusrcb    = ctrl.alusrcb;
    pcsrc      = ctrl.pcsrc;
    iord       = ctrl.iord;
    regdst     = ctrl.regdst;
    memtoreg   = ctrl.memtoreg;
    branch     = ctrl.branch;
    illegal_op = ctrl.illegal_op;
    irwrite    = ctrl.irwrite  & reset;
    memwrite   = ctrl.memwrite & reset;
    regwrite   = ctrl.regwrite & reset;
    pcwrite    = ctrl.pcwrite  & reset;
    state      = state_q;
  end

endmodule
